// File: rtl/dda_pkg.sv
// Shared types for the DDA result stream and the wall column buffer.
package dda_pkg;

    localparam int unsigned SCREEN_WIDTH_DEF = 320;
    localparam int unsigned COL_AW           = $clog2(SCREEN_WIDTH_DEF);

    typedef struct packed {
        logic [8:0]  hcount_ray;
        logic [7:0]  line_height;
        logic        wall_type;
        logic [3:0]  map_data;
        logic [15:0] wall_x;
    } dda_result_t;

    typedef struct packed {
        logic [7:0]  line_height;
        logic        wall_type;
        logic [3:0]  map_data;
        logic [15:0] wall_x;
    } column_entry_t;

    typedef enum logic {FILL, DONE} writer_state_t;

    function automatic column_entry_t to_entry(dda_result_t r);
        return '{line_height: r.line_height, wall_type: r.wall_type,
                 map_data: r.map_data, wall_x: r.wall_x};
    endfunction

endpackage

// File: rtl/column_ram.sv
// Simple dual-port column RAM: stream-side write, display-side registered read.
module column_ram
    import dda_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          pixel_clk_in,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  column_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output column_entry_t rdata
);

    column_entry_t mem [DEPTH];

    always_ff @(posedge pixel_clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wall_column_buffer.sv
// Ping-pong column buffer between the DDA result stream and the pixel query path.
// Optional statistics counters are enabled by defining WALL_COLUMN_BUF_STATS_EN.
module wall_column_buffer
    import dda_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 180
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        dda_out_tvalid,
    input  logic [37:0] dda_out_tdata,
    input  logic        dda_out_tlast,
    output logic        dda_out_tready,
    input  logic        new_frame_in,
    input  logic [8:0]  hcount_in,
    input  logic [7:0]  vcount_in,
    output logic        display_valid_out,
    output logic        wall_out,
    output logic        wallType_out,
    output logic [3:0]  mapData_out,
`ifdef WALL_COLUMN_BUF_STATS_EN
    output logic [15:0] wallX_out,
    output logic [15:0] frames_done_out,
    output logic [15:0] dropped_rays_out,
    output logic [15:0] repeat_frames_out
`else
    output logic [15:0] wallX_out
`endif
);

    localparam int unsigned DEPTH = 2 * SCREEN_WIDTH;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [9:0]  WIDTH_10 = 10'(SCREEN_WIDTH);
    localparam logic signed [9:0] MID = 10'(SCREEN_HEIGHT / 2);
    localparam logic signed [9:0] HGT = 10'(SCREEN_HEIGHT);

    writer_state_t state_q, state_d;
    logic          fill_bank_q, display_bank_q, display_valid_q, started_q;
    logic          swap, accept, beat_in_range, we;
    logic [AW-1:0] waddr, raddr;
    dda_result_t   beat;
    column_entry_t rdata;

    assign beat           = dda_out_tdata;
    assign dda_out_tready = started_q && (state_q == FILL);
    assign accept         = dda_out_tvalid && dda_out_tready;
    assign beat_in_range  = {1'b0, beat.hcount_ray} < WIDTH_10;
    assign we             = accept && beat_in_range;
    assign waddr          = fill_bank_q ? AW'(SCREEN_WIDTH) + AW'(beat.hcount_ray)
                                        : AW'(beat.hcount_ray);
    assign display_valid_out = display_valid_q;

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        unique case (state_q)
            FILL: if (accept && dda_out_tlast) state_d = DONE;
            DONE: begin
                if (new_frame_in) begin
                    state_d = FILL;
                    swap    = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= FILL;
            started_q       <= 1'b0;
            fill_bank_q     <= 1'b0;
            display_bank_q  <= 1'b0;
            display_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (swap) begin
                display_bank_q  <= fill_bank_q;
                fill_bank_q     <= ~fill_bank_q;
                display_valid_q <= 1'b1;
            end
        end
    end

    column_ram #(.DEPTH(DEPTH), .AW(AW)) u_column_ram (
        .pixel_clk_in (pixel_clk_in),
        .we           (we),
        .waddr        (waddr),
        .wdata        (to_entry(beat)),
        .raddr        (raddr),
        .rdata        (rdata)
    );

    // Read stage 1: RAM lookup; out-of-range columns read a harmless in-bounds address.
    logic       h_ok, h_ok_q;
    logic [7:0] vcount_q;

    assign h_ok  = {1'b0, hcount_in} < WIDTH_10;
    assign raddr = !h_ok ? '0 : (display_bank_q ? AW'(SCREEN_WIDTH) + AW'(hcount_in)
                                                : AW'(hcount_in));

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            h_ok_q   <= 1'b0;
            vcount_q <= '0;
        end else begin
            h_ok_q   <= h_ok;
            vcount_q <= vcount_in;
        end
    end

    // Read stage 2: signed span arithmetic so tall walls clamp instead of wrapping.
    logic signed [9:0] half, span_start, span_end, v_s;
    logic              wall_d;

    always_comb begin
        half       = signed'({3'b000, rdata.line_height[7:1]});
        v_s        = signed'({2'b00, vcount_q});
        span_start = MID - half;
        if (span_start[9]) span_start = '0;
        span_end   = MID + half;
        if (span_end > HGT) span_end = HGT;
        wall_d = display_valid_q && h_ok_q && (v_s >= span_start) && (v_s < span_end);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wall_out     <= 1'b0;
            wallType_out <= 1'b0;
            mapData_out  <= '0;
            wallX_out    <= '0;
        end else begin
            wall_out     <= wall_d;
            wallType_out <= rdata.wall_type;
            mapData_out  <= rdata.map_data;
            wallX_out    <= rdata.wall_x;
        end
    end

`ifdef WALL_COLUMN_BUF_STATS_EN
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frames_done_out   <= '0;
            dropped_rays_out  <= '0;
            repeat_frames_out <= '0;
        end else begin
            if (swap) frames_done_out <= frames_done_out + 16'd1;
            if (accept && !beat_in_range && dropped_rays_out != '1) begin
                dropped_rays_out <= dropped_rays_out + 16'd1;
            end
            if (state_q == FILL && new_frame_in && repeat_frames_out != '1) begin
                repeat_frames_out <= repeat_frames_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wall_column_buffer.sv
// Randomized bench for wall_column_buffer against a frame-level reference model.
module tb_wall_column_buffer;

    localparam int W = 320;
    localparam int H = 180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tvalid = 1'b0, tlast = 1'b0, tready, new_frame = 1'b0;
    logic [37:0] tdata = '0;
    logic [8:0]  hcount = '0;
    logic [7:0]  vcount = '0;
    logic        dv_out, wall_out, wtype_out;
    logic [3:0]  map_out;
    logic [15:0] wallx_out;
`ifdef WALL_COLUMN_BUF_STATS_EN
    logic [15:0] frames_out, dropped_out, repeat_out;
`endif

    always #5 clk = ~clk;

    wall_column_buffer dut (
        .pixel_clk_in      (clk),
        .rst_n_in          (rst_n),
        .dda_out_tvalid    (tvalid),
        .dda_out_tdata     (tdata),
        .dda_out_tlast     (tlast),
        .dda_out_tready    (tready),
        .new_frame_in      (new_frame),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .display_valid_out (dv_out),
        .wall_out          (wall_out),
        .wallType_out      (wtype_out),
        .mapData_out       (map_out),
`ifdef WALL_COLUMN_BUF_STATS_EN
        .wallX_out         (wallx_out),
        .frames_done_out   (frames_out),
        .dropped_rays_out  (dropped_out),
        .repeat_frames_out (repeat_out)
`else
        .wallX_out         (wallx_out)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: two banks of columns, plus which bank is filling/displayed.
    logic [28:0] m_mem [0:2*W-1];
    bit          m_known [0:2*W-1];
    bit          m_fill, m_disp, m_dv, m_done, m_up, last_acc;
    int          m_frames, m_dropped, m_repeat;
    bit          rq = 1'b1;
    // Query captured at the previous edge, waiting to emerge at the next one.
    bit          s1_v;
    int          s1_h, s1_line;
    logic [28:0] s1_data;
    bit          s1_known;

    function automatic logic [37:0] mk(int col, int lh);
        logic [8:0] c = col[8:0];
        logic [7:0] l = lh[7:0];
        return {c, l, 21'($urandom)};
    endfunction

    task automatic model_clear();
        m_fill = 0; m_disp = 0; m_dv = 0; m_done = 0; m_up = 0;
        m_frames = 0; m_dropped = 0; m_repeat = 0; s1_v = 0;
    endtask

    task automatic tick();
        bit   e_v, e_wall, e_wall_ok, e_data_ok, acc;
        logic [28:0] e_data;
        int   half, st, en, col;
        if (rq) begin
            hcount = 9'($urandom_range(0, 339));
            vcount = 8'($urandom_range(0, H - 1));
        end
        e_v = s1_v;
        e_data = s1_data;
        half = int'(s1_data[28:21]) / 2;
        st = H / 2 - half; if (st < 0) st = 0;
        en = H / 2 + half; if (en > H) en = H;
        e_wall    = m_dv && s1_h < W && s1_line >= st && s1_line < en;
        e_wall_ok = !(m_dv && s1_h < W && !s1_known);
        e_data_ok = m_dv && s1_h < W && s1_known;
        s1_v = 1; s1_h = int'(hcount); s1_line = int'(vcount);
        if (s1_h < W) begin
            s1_data  = m_mem[int'(m_disp) * W + s1_h];
            s1_known = m_known[int'(m_disp) * W + s1_h];
        end else begin
            s1_known = 1;
        end
        acc = tvalid && m_up && !m_done;
        col = int'(tdata[37:29]);
        if (acc) begin
            if (col < W) begin
                m_mem[int'(m_fill) * W + col]   = tdata[28:0];
                m_known[int'(m_fill) * W + col] = 1;
            end else if (m_dropped < 16'hFFFF) m_dropped++;
        end
        if (!m_done) begin
            if (new_frame && m_repeat < 16'hFFFF) m_repeat++;
            if (acc && tlast) m_done = 1;
        end else if (new_frame) begin
            m_disp = m_fill; m_fill = !m_fill; m_dv = 1; m_done = 0;
            m_frames = (m_frames + 1) & 16'hFFFF;
        end
        m_up = 1;
        last_acc = acc;
        @(posedge clk); #1;
        check("tready", 32'(tready), 32'(m_up && !m_done));
        check("display_valid", 32'(dv_out), 32'(m_dv));
        if (e_v && e_wall_ok) check("wall", 32'(wall_out), 32'(e_wall));
        if (e_v && e_data_ok) begin
            check("wallType", 32'(wtype_out), 32'(e_data[20]));
            check("mapData", 32'(map_out), 32'(e_data[19:16]));
            check("wallX", 32'(wallx_out), 32'(e_data[15:0]));
        end
`ifdef WALL_COLUMN_BUF_STATS_EN
        check("frames_done", 32'(frames_out), 32'(m_frames));
        check("dropped_rays", 32'(dropped_out), 32'(m_dropped));
        check("repeat_frames", 32'(repeat_out), 32'(m_repeat));
`endif
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_tready", 32'(tready), 0);
        check("rst_display_valid", 32'(dv_out), 0);
        check("rst_wall", 32'(wall_out), 0);
        check("rst_wallType", 32'(wtype_out), 0);
        check("rst_mapData", 32'(map_out), 0);
        check("rst_wallX", 32'(wallx_out), 0);
        model_clear();
        tvalid = 0; tlast = 0; new_frame = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send_beat(int col, int lh, bit tl);
        int guard = 0;
        tvalid = 1; tdata = mk(col, lh); tlast = tl;
        do begin
            tick();
            guard++;
        end while (!last_acc && guard < 64);
        check("beat_accepted", 32'(last_acc), 1);
        tvalid = 0; tlast = 0;
    endtask

    task automatic send_frame(int n, int lh, bit tl);
        for (int i = 0; i < n; i++) begin
            send_beat(i, (lh < 0) ? int'($urandom_range(0, 255)) : lh, tl && (i == n - 1));
        end
    endtask

    task automatic pulse_new_frame();
        new_frame = 1; tick(); new_frame = 0;
    endtask

    task automatic query(int h, int v);
        rq = 0; hcount = 9'(h); vcount = 8'(v); tick(); rq = 1;
    endtask

    initial begin
        do_reset();
        tick();
        // Full frame, lineHeight 60, then swap and probe the span edges.
        send_frame(W, 60, 1);
        repeat (3) tick();
        pulse_new_frame();
        query(5, 59); query(5, 60); query(5, 119); query(5, 120);
        repeat (20) tick();

        // tvalid held across tlast; next frame waits for the swap, then fills bank 0.
        send_frame(W, -1, 1);
        tvalid = 1; tdata = mk(0, 100); tlast = 0;
        repeat (5) tick();
        new_frame = 1; tick(); new_frame = 0;
        repeat (2) tick();
        tvalid = 0;
        for (int i = 1; i < 100; i++) send_beat(i, int'($urandom_range(0, 255)), i == 99);
        pulse_new_frame();
        repeat (20) tick();

        // Out-of-range beat is dropped; a full-height wall covers every line.
        send_beat(400, 255, 0);
        send_beat(7, 255, 1);
        pulse_new_frame();
        query(7, 0); query(7, 90); query(7, 179); query(400, 90);
        repeat (10) tick();

        // new_frame during a half-filled frame repeats the old frame.
        send_frame(W / 2, -1, 0);
        pulse_new_frame();
        repeat (10) tick();
        for (int i = W / 2; i < W; i++) send_beat(i, int'($urandom_range(0, 255)), i == W - 1);

        // tlast and new_frame together: no swap until the following pulse.
        pulse_new_frame();
        send_frame(10, -1, 0);
        tvalid = 1; tdata = mk(10, 40); tlast = 1; new_frame = 1;
        tick();
        tvalid = 0; tlast = 0; new_frame = 0;
        repeat (4) tick();
        pulse_new_frame();
        repeat (10) tick();

        // Reset mid-fill discards the partial frame and clears display_valid.
        send_frame(50, -1, 0);
        do_reset();
        repeat (5) tick();
        send_frame(W, -1, 1);
        pulse_new_frame();
        repeat (10) tick();

        // Randomized frames with gaps, stray columns and stray new_frame pulses.
        for (int f = 0; f < 6; f++) begin
            int n = int'($urandom_range(20, 200));
            for (int i = 0; i < n; i++) begin
                int col = ($urandom_range(0, 9) == 0) ? int'($urandom_range(W, 511))
                                                      : int'($urandom_range(0, W - 1));
                if ($urandom_range(0, 3) == 0) tick();
                if ($urandom_range(0, 40) == 0) pulse_new_frame();
                send_beat(col, int'($urandom_range(0, 255)), i == n - 1);
            end
            repeat (int'($urandom_range(1, 6))) tick();
            pulse_new_frame();
            repeat (int'($urandom_range(5, 30))) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
